// File: rtl/pitch_score_pkg.sv
// rtl/pitch_score_pkg.sv - FSM encoding and tolerance band constants for the pitch scorer
package pitch_score_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_FOLD,
      ST_SCORE,
      ST_ACC,
      ST_DIV
   } state_t;

   // Band edges are these multiples of the base tolerance unit.
   localparam int BAND0_MUL = 1;
   localparam int BAND1_MUL = 2;
   localparam int BAND2_MUL = 4;
   localparam int BAND3_MUL = 8;

   function automatic int band_score(input int max_score, input int band);
      case (band)
         0:       return max_score;
         1:       return (8 * max_score) / 10;
         2:       return max_score / 2;
         3:       return max_score / 5;
         default: return 0;
      endcase
   endfunction

endpackage

// File: rtl/pitch_fifo.sv
// rtl/pitch_fifo.sv - synchronous FIFO with registered read data, occupancy count and drop flag
module pitch_fifo #(
   parameter int WIDTH = 15,
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     clear,
   input  logic                     wr_en,
   input  logic [WIDTH-1:0]         din,
   input  logic                     rd_en,
   output logic [WIDTH-1:0]         dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     drop
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             push;
   logic             pop;

   assign full  = (count == (AW+1)'(DEPTH));
   assign empty = (count == '0);
   assign push  = wr_en & ~full;
   assign pop   = rd_en & ~empty;
   assign drop  = wr_en & full;

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= din;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         dout   <= '0;
      end else if (clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         dout   <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop) begin
            dout   <= mem[rd_ptr];
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({push, pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/pitch_score_pipeline.sv
// rtl/pitch_score_pipeline.sv - paired pitch FIFOs, octave fold, band scoring and running average
module pitch_score_pipeline
   import pitch_score_pkg::*;
#(
   parameter int FREQ_W    = 15,
   parameter int DEPTH     = 16,
   parameter int SCORE_W   = 4,
   parameter int MAX_SCORE = 10,
   parameter int TOL_SHIFT = 5,
   parameter int CNT_W     = 16
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        clear,
   input  logic                        enable,
   input  logic                        octave_fold,
   input  logic                        song_wr_en,
   input  logic [FREQ_W-1:0]           song_din,
   input  logic                        ref_wr_en,
   input  logic [FREQ_W-1:0]           ref_din,
   output logic                        song_full,
   output logic                        ref_full,
   output logic [$clog2(DEPTH):0]      song_count,
   output logic [$clog2(DEPTH):0]      ref_count,
   output logic                        overflow_err,
   output logic [SCORE_W-1:0]          score,
   output logic                        score_valid,
   output logic [SCORE_W-1:0]          score_avg,
   output logic                        avg_valid,
   output logic [CNT_W-1:0]            sample_count
);

   localparam int SUM_W = CNT_W + SCORE_W;
   localparam int DCW   = $clog2(SUM_W + 1);
   localparam int XW    = FREQ_W + 4;
   localparam int SC0   = band_score(MAX_SCORE, 0);
   localparam int SC1   = band_score(MAX_SCORE, 1);
   localparam int SC2   = band_score(MAX_SCORE, 2);
   localparam int SC3   = band_score(MAX_SCORE, 3);

   state_t              state, nstate;
   logic [FREQ_W-1:0]   song_dout, ref_dout;
   logic                song_empty, ref_empty, song_drop, ref_drop;
   logic                rd_en;
   logic                fold_q;
   logic [FREQ_W:0]     s_q, s_step;
   logic [FREQ_W-1:0]   r_q;
   logic [SUM_W-1:0]    sum_q, div_q, div_nx;
   logic [SUM_W:0]      rem_q, rem_sh, rem_nx;
   logic [DCW-1:0]      div_cnt;
   logic [XW-1:0]       d, u;
   logic [SCORE_W-1:0]  score_calc, avg_clip;

   pitch_fifo #(.WIDTH(FREQ_W), .DEPTH(DEPTH)) u_song_fifo (
      .clk(clk), .rst_n(rst_n), .clear(clear), .wr_en(song_wr_en), .din(song_din),
      .rd_en(rd_en), .dout(song_dout), .full(song_full), .empty(song_empty),
      .count(song_count), .drop(song_drop)
   );

   pitch_fifo #(.WIDTH(FREQ_W), .DEPTH(DEPTH)) u_ref_fifo (
      .clk(clk), .rst_n(rst_n), .clear(clear), .wr_en(ref_wr_en), .din(ref_din),
      .rd_en(rd_en), .dout(ref_dout), .full(ref_full), .empty(ref_empty),
      .count(ref_count), .drop(ref_drop)
   );

   // Out of range means outside [r, 2r); a zero song value can never be folded in.
   function automatic logic needs_fold(input logic [FREQ_W:0] s, input logic [FREQ_W-1:0] r);
      return (s >= {r, 1'b0}) || ((s < {1'b0, r}) && (s != '0));
   endfunction

   assign s_step = (s_q >= {r_q, 1'b0}) ? (s_q >> 1) : (s_q << 1);

   always_comb begin
      d = (s_q >= {1'b0, r_q}) ? XW'(s_q - {1'b0, r_q}) : XW'({1'b0, r_q} - s_q);
      u = XW'(r_q >> TOL_SHIFT);
      if (u == '0) begin
         u = XW'(1);
      end
      score_calc = '0;
      if (r_q == '0) begin
         score_calc = (s_q == '0) ? SCORE_W'(MAX_SCORE) : '0;
      end else if (s_q == '0) begin
         score_calc = '0;
      end else if (d <= XW'(BAND0_MUL) * u) begin
         score_calc = SCORE_W'(SC0);
      end else if (d <= XW'(BAND1_MUL) * u) begin
         score_calc = SCORE_W'(SC1);
      end else if (d <= XW'(BAND2_MUL) * u) begin
         score_calc = SCORE_W'(SC2);
      end else if (d <= XW'(BAND3_MUL) * u) begin
         score_calc = SCORE_W'(SC3);
      end
   end

   // One restoring-division step per cycle against the current sample count.
   always_comb begin
      rem_sh   = {rem_q[SUM_W-1:0], div_q[SUM_W-1]};
      rem_nx   = rem_sh;
      div_nx   = {div_q[SUM_W-2:0], 1'b0};
      if (rem_sh >= (SUM_W+1)'(sample_count)) begin
         rem_nx = rem_sh - (SUM_W+1)'(sample_count);
         div_nx = {div_q[SUM_W-2:0], 1'b1};
      end
      avg_clip = (div_nx > SUM_W'(MAX_SCORE)) ? SCORE_W'(MAX_SCORE) : div_nx[SCORE_W-1:0];
   end

   always_comb begin
      nstate = state;
      rd_en  = 1'b0;
      case (state)
         ST_IDLE: begin
            if (enable && !song_empty && !ref_empty && !clear) begin
               rd_en  = 1'b1;
               nstate = ST_LOAD;
            end
         end
         ST_LOAD: begin
            if (fold_q && (ref_dout != '0) && needs_fold({1'b0, song_dout}, ref_dout)) begin
               nstate = ST_FOLD;
            end else begin
               nstate = ST_SCORE;
            end
         end
         ST_FOLD: begin
            if (!needs_fold(s_step, r_q)) begin
               nstate = ST_SCORE;
            end
         end
         ST_SCORE: nstate = ST_ACC;
         ST_ACC:   nstate = (sample_count != '1) ? ST_DIV : ST_IDLE;
         ST_DIV: begin
            if (div_cnt == DCW'(SUM_W)) begin
               nstate = ST_IDLE;
            end
         end
         default:  nstate = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= ST_IDLE;
         fold_q       <= 1'b0;
         s_q          <= '0;
         r_q          <= '0;
         sum_q        <= '0;
         div_q        <= '0;
         rem_q        <= '0;
         div_cnt      <= '0;
         overflow_err <= 1'b0;
         score        <= '0;
         score_valid  <= 1'b0;
         score_avg    <= '0;
         avg_valid    <= 1'b0;
         sample_count <= '0;
      end else if (clear) begin
         state        <= ST_IDLE;
         sum_q        <= '0;
         div_cnt      <= '0;
         overflow_err <= 1'b0;
         score        <= '0;
         score_valid  <= 1'b0;
         score_avg    <= '0;
         avg_valid    <= 1'b0;
         sample_count <= '0;
      end else begin
         state        <= nstate;
         score_valid  <= 1'b0;
         avg_valid    <= 1'b0;
         overflow_err <= overflow_err | song_drop | ref_drop;
         case (state)
            ST_IDLE: begin
               if (rd_en) begin
                  fold_q <= octave_fold;
               end
            end
            ST_LOAD: begin
               s_q <= {1'b0, song_dout};
               r_q <= ref_dout;
            end
            ST_FOLD:  s_q <= s_step;
            ST_SCORE: begin
               score       <= score_calc;
               score_valid <= 1'b1;
            end
            ST_ACC: begin
               div_cnt <= '0;
               if (sample_count != '1) begin
                  sum_q        <= sum_q + SUM_W'(score);
                  sample_count <= sample_count + CNT_W'(1);
               end
            end
            ST_DIV: begin
               div_cnt <= div_cnt + DCW'(1);
               if (div_cnt == '0) begin
                  div_q <= sum_q;
                  rem_q <= '0;
               end else begin
                  div_q <= div_nx;
                  rem_q <= rem_nx;
                  if (div_cnt == DCW'(SUM_W)) begin
                     score_avg <= avg_clip;
                     avg_valid <= 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_pitch_score_pipeline.sv
// tb/tb_pitch_score_pipeline.sv - scoreboard bench for pitch_score_pipeline
module tb_pitch_score_pipeline;

   localparam int FREQ_W    = 15;
   localparam int DEPTH     = 16;
   localparam int SCORE_W   = 4;
   localparam int MAX_SCORE = 10;
   localparam int TOL_SHIFT = 5;
   localparam int CNT_W     = 16;
   localparam int SUM_W     = CNT_W + SCORE_W;
   localparam int FMAX      = (1 << FREQ_W) - 1;

   logic                     clk = 1'b0;
   logic                     rst_n = 1'b1;
   logic                     clear = 1'b0;
   logic                     enable = 1'b0;
   logic                     octave_fold = 1'b0;
   logic                     song_wr_en = 1'b0;
   logic [FREQ_W-1:0]        song_din = '0;
   logic                     ref_wr_en = 1'b0;
   logic [FREQ_W-1:0]        ref_din = '0;
   logic                     song_full, ref_full, overflow_err;
   logic [$clog2(DEPTH):0]   song_count, ref_count;
   logic [SCORE_W-1:0]       score, score_avg;
   logic                     score_valid, avg_valid;
   logic [CNT_W-1:0]         sample_count;

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;
   int last_sv_cyc = -1;
   int msum = 0;
   int mcnt = 0;
   int exp_score_q[$];
   int exp_avg_q[$];
   int exp_cnt_q[$];

   pitch_score_pipeline #(
      .FREQ_W(FREQ_W), .DEPTH(DEPTH), .SCORE_W(SCORE_W), .MAX_SCORE(MAX_SCORE),
      .TOL_SHIFT(TOL_SHIFT), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .rst_n(rst_n), .clear(clear), .enable(enable), .octave_fold(octave_fold),
      .song_wr_en(song_wr_en), .song_din(song_din), .ref_wr_en(ref_wr_en), .ref_din(ref_din),
      .song_full(song_full), .ref_full(ref_full), .song_count(song_count), .ref_count(ref_count),
      .overflow_err(overflow_err), .score(score), .score_valid(score_valid),
      .score_avg(score_avg), .avg_valid(avg_valid), .sample_count(sample_count)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic flag(input string name);
      vectors++;
      miscompares++;
      $display("FAIL %s (t=%0t)", name, $time);
   endtask

   function automatic int model_score(input int s_in, input int r, input bit fold);
      int s, d, u;
      s = s_in;
      if (fold && r != 0) begin
         for (int k = 0; k < 64; k++) begin
            if (s >= 2 * r) s = s / 2;
            else if (s != 0 && s < r) s = s * 2;
            else break;
         end
      end
      if (r == 0) return (s == 0) ? MAX_SCORE : 0;
      if (s == 0) return 0;
      d = (s > r) ? s - r : r - s;
      u = r / (1 << TOL_SHIFT);
      if (u < 1) u = 1;
      if (d <= u)     return MAX_SCORE;
      if (d <= 2 * u) return (8 * MAX_SCORE) / 10;
      if (d <= 4 * u) return MAX_SCORE / 2;
      if (d <= 8 * u) return MAX_SCORE / 5;
      return 0;
   endfunction

   function automatic int model_avg();
      int a;
      a = msum / mcnt;
      return (a > MAX_SCORE) ? MAX_SCORE : a;
   endfunction

   // mode: 0 no expectation, 1 score only, 2 score plus average update
   task automatic push_pair(input int s, input int r, input int mode);
      int sc;
      song_din   = FREQ_W'(s);
      ref_din    = FREQ_W'(r);
      song_wr_en = 1'b1;
      ref_wr_en  = 1'b1;
      if (mode != 0) begin
         sc = model_score(s, r, octave_fold);
         exp_score_q.push_back(sc);
         if (mode == 2) begin
            msum += sc;
            mcnt++;
            exp_avg_q.push_back(model_avg());
            exp_cnt_q.push_back(mcnt);
         end
      end
      @(posedge clk);
      #1;
      song_wr_en = 1'b0;
      ref_wr_en  = 1'b0;
   endtask

   task automatic push_song(input int s);
      song_din   = FREQ_W'(s);
      song_wr_en = 1'b1;
      @(posedge clk);
      #1;
      song_wr_en = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 4000; i++) begin
         if (exp_score_q.size() == 0 && exp_avg_q.size() == 0) break;
         @(posedge clk);
      end
      if (exp_score_q.size() != 0 || exp_avg_q.size() != 0) begin
         flag("drain_timeout");
         exp_score_q.delete();
         exp_avg_q.delete();
         exp_cnt_q.delete();
      end
      @(posedge clk);
      #1;
   endtask

   task automatic clear_all();
      clear = 1'b1;
      @(posedge clk);
      #1;
      clear = 1'b0;
      msum = 0;
      mcnt = 0;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_score"}, int'(score), 0);
      check({tag, "_score_valid"}, int'(score_valid), 0);
      check({tag, "_score_avg"}, int'(score_avg), 0);
      check({tag, "_avg_valid"}, int'(avg_valid), 0);
      check({tag, "_sample_count"}, int'(sample_count), 0);
      check({tag, "_song_count"}, int'(song_count), 0);
      check({tag, "_ref_count"}, int'(ref_count), 0);
      check({tag, "_overflow_err"}, int'(overflow_err), 0);
      check({tag, "_song_full"}, int'(song_full), 0);
      check({tag, "_ref_full"}, int'(ref_full), 0);
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         if (score_valid) begin
            last_sv_cyc = cyc;
            if (exp_score_q.size() == 0) flag("unexpected_score_valid");
            else check("score", int'(score), exp_score_q.pop_front());
         end
         if (avg_valid) begin
            if (exp_avg_q.size() == 0) begin
               flag("unexpected_avg_valid");
            end else begin
               check("score_avg", int'(score_avg), exp_avg_q.pop_front());
               check("sample_count", int'(sample_count), exp_cnt_q.pop_front());
               check("avg_latency", cyc - last_sv_cyc, SUM_W + 2);
            end
         end
      end
   end

   initial begin
      int r, s;
      #1 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_all_zero("reset");
      rst_n  = 1'b1;
      enable = 1'b1;
      @(posedge clk);
      #1;

      repeat (4) push_pair(440, 440, 2);
      drain();
      check("dir_count4", int'(sample_count), 4);
      check("dir_avg_equal", int'(score_avg), model_avg());

      clear_all();
      push_pair(452, 440, 2);
      push_pair(470, 440, 2);
      push_pair(520, 440, 2);
      push_pair(700, 440, 2);
      drain();
      check("band_avg", int'(score_avg), model_avg());

      octave_fold = 1'b1;
      push_pair(880, 440, 2);
      drain();
      octave_fold = 1'b0;
      push_pair(880, 440, 2);
      drain();

      push_pair(0, 0, 2);
      push_pair(200, 0, 2);
      push_pair(0, 300, 2);
      drain();

      clear_all();
      for (int i = 0; i < DEPTH; i++) push_song(100 + 10 * i);
      check("ovf_full", int'(song_full), 1);
      check("ovf_count", int'(song_count), DEPTH);
      check("ovf_err_before", int'(overflow_err), 0);
      push_song(999);
      check("ovf_err_after", int'(overflow_err), 1);
      check("ovf_count_after", int'(song_count), DEPTH);
      check("ovf_ref_count", int'(ref_count), 0);
      repeat (20) @(posedge clk);
      #1;
      check("ovf_no_pop", int'(song_count), DEPTH);
      clear_all();
      check("ovf_cleared_count", int'(song_count), 0);
      check("ovf_cleared_err", int'(overflow_err), 0);
      check("ovf_cleared_full", int'(song_full), 0);

      for (int ph = 0; ph < 4; ph++) begin
         octave_fold = ($urandom_range(0, 1) != 0);
         for (int k = 0; k < 6; k++) begin
            r = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 3000));
            case ($urandom_range(0, 3))
               0:       s = r + int'($urandom_range(0, r / 3)) - r / 6;
               1:       s = ($urandom_range(0, 1) != 0) ? r * 2 : r / 2;
               2:       s = int'($urandom_range(0, FMAX));
               default: s = r;
            endcase
            if (s < 0) s = 0;
            if (s > FMAX) s = FMAX;
            push_pair(s, r, 2);
         end
         drain();
      end

      octave_fold = 1'b1;
      push_pair(30000, 100, 0);
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (song_count == 0) break;
      end
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check_all_zero("rst_mid_fold");
      #2;
      rst_n = 1'b1;
      octave_fold = 1'b0;
      msum = 0;
      mcnt = 0;
      @(posedge clk);
      #1;

      push_pair(452, 440, 2);
      drain();
      push_pair(440, 440, 1);
      push_pair(500, 440, 0);
      begin
         bit seen;
         seen = 1'b0;
         for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (score_valid) begin
               seen = 1'b1;
               break;
            end
         end
         if (!seen) flag("clr_div_no_score");
      end
      repeat (5) @(posedge clk);
      #1;
      clear_all();
      check("clr_div_song_count", int'(song_count), 0);
      check("clr_div_ref_count", int'(ref_count), 0);
      check("clr_div_sample_count", int'(sample_count), 0);
      repeat (SUM_W + 10) @(posedge clk);
      #1;
      exp_score_q.delete();

      push_pair(445, 440, 2);
      drain();
      check("final_count", int'(sample_count), 1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
